ds1302_responder: RTL

Synthesizable responder for the DS1302 three-wire serial interface: it plays the RTC chip's role, so the team's `ds1302_2` master can be exercised in simulation and loop-back on the board without a physical DS1302. It oversamples SCLK, NRST and DATA on the system clock, decodes command bytes, and serves a 9-byte clock-register file and a 31-byte RAM in single-byte and burst modes. Each committed write is also reported on a strobe port for scoreboarding.

---
 rtl/ds1302_responder_if.sv | 22 ++
 rtl/ds1302_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_responder_if.sv
// DS1302 three-wire bus as seen by the responder, plus the write-report port.
interface ds1302_responder_if;
    logic       sclk;
    logic       nrst;
    logic       data_i;
    logic       data_o;
    logic       data_oe;
    logic       wr_stb;
    logic       wr_ram;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output sclk, nrst, data_i,
        input  data_o, data_oe, wr_stb, wr_ram, wr_addr, wr_data
    );

    modport slave (
        input  sclk, nrst, data_i,
        output data_o, data_oe, wr_stb, wr_ram, wr_addr, wr_data
    );
endinterface

// File: rtl/ds1302_responder.sv
// DS1302 RTC stand-in: oversamples the three-wire bus, serves 9 clock registers
// and 31 RAM bytes in single and burst modes, and reports every committed write.
module ds1302_responder #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               clr,
    ds1302_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CK_RST [0:8] = '{
        8'h80, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h5C
    };

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] nrst_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sclk_s;
    logic                   nrst_s;
    logic                   sclk_d;
    logic                   data_d;
    logic                   rise_q;
    logic                   fall_q;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [4:0] cur_addr;
    logic       is_ram;
    logic       burst;
    logic [7:0] rd_byte;
    logic       rd_last;

    logic       data_o_q;
    logic       data_oe_q;
    logic       wr_stb_q;
    logic       wr_ram_q;
    logic [4:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic [7:0] ck_reg [0:8];
    logic [7:0] ram    [0:30];

    logic [7:0] shift_nxt;
    logic [4:0] cmd_addr;
    logic       cmd_burst;
    logic       at_limit;
    logic       addr_valid;
    logic       wp_block;
    logic       wr_ok;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign nrst_s = nrst_sync[SYNC_STAGES-1];

    assign shift_nxt  = {data_d, shreg[7:1]};
    assign cmd_addr   = shift_nxt[5:1];
    assign cmd_burst  = &cmd_addr;
    // Burst addresses count up from 0, so the last byte is simply the top address.
    assign at_limit   = !burst || (cur_addr == (is_ram ? 5'd30 : 5'd7));
    assign addr_valid = is_ram ? (cur_addr != 5'd31) : (cur_addr <= 5'd8);
    assign wp_block   = ck_reg[7][7] && !(!burst && !is_ram && cur_addr == 5'd7);
    assign wr_ok      = addr_valid && !wp_block;

    assign bus.data_o  = data_o_q;
    assign bus.data_oe = data_oe_q;
    assign bus.wr_stb  = wr_stb_q;
    assign bus.wr_ram  = wr_ram_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

    function automatic logic [7:0] rd_val(input logic ram_sel, input logic [4:0] a);
        if (ram_sel)
            return (a == 5'd31) ? 8'h00 : ram[a];
        else
            return (a <= 5'd8) ? ck_reg[a[3:0]] : 8'h00;
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sclk_sync <= '0;
            nrst_sync <= '0;
            data_sync <= '0;
            sclk_d    <= 1'b0;
            data_d    <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            nrst_sync <= {nrst_sync[SYNC_STAGES-2:0], bus.nrst};
            data_sync <= {data_sync[SYNC_STAGES-2:0], bus.data_i};
            sclk_d    <= sclk_s;
            data_d    <= data_sync[SYNC_STAGES-1];
            rise_q    <= sclk_s & ~sclk_d;
            fall_q    <= ~sclk_s & sclk_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            cur_addr  <= '0;
            is_ram    <= 1'b0;
            burst     <= 1'b0;
            rd_byte   <= '0;
            rd_last   <= 1'b0;
            data_o_q  <= 1'b0;
            data_oe_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_ram_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int unsigned i = 0; i < 9; i++)
                ck_reg[i] <= CK_RST[i];
            for (int unsigned i = 0; i < 31; i++)
                ram[i] <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            // Abort wins over any edge seen in the same cycle.
            if (!nrst_s) begin
                state     <= ST_IDLE;
                data_oe_q <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                    end

                    ST_CMD: begin
                        if (rise_q) begin
                            shreg   <= shift_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                is_ram   <= shift_nxt[6];
                                burst    <= cmd_burst;
                                cur_addr <= cmd_burst ? 5'd0 : cmd_addr;
                                rd_last  <= 1'b0;
                                if (!shift_nxt[7])
                                    state <= ST_IGNORE;
                                else if (shift_nxt[0]) begin
                                    rd_byte <= rd_val(shift_nxt[6], cmd_burst ? 5'd0 : cmd_addr);
                                    state   <= ST_RDATA;
                                end else
                                    state <= ST_WDATA;
                            end
                        end
                    end

                    ST_WDATA: begin
                        if (rise_q) begin
                            shreg   <= shift_nxt;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (wr_ok) begin
                                    wr_stb_q  <= 1'b1;
                                    wr_ram_q  <= is_ram;
                                    wr_addr_q <= cur_addr;
                                    wr_data_q <= shift_nxt;
                                    if (is_ram)
                                        ram[cur_addr] <= shift_nxt;
                                    else
                                        ck_reg[cur_addr[3:0]] <= shift_nxt;
                                end
                                if (at_limit)
                                    state <= ST_IGNORE;
                                else
                                    cur_addr <= cur_addr + 5'd1;
                            end
                        end
                    end

                    ST_RDATA: begin
                        if (fall_q) begin
                            if (rd_last) begin
                                data_oe_q <= 1'b0;
                                state     <= ST_IGNORE;
                            end else begin
                                data_o_q  <= rd_byte[0];
                                data_oe_q <= 1'b1;
                                rd_byte   <= rd_byte >> 1;
                                bit_cnt   <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    if (at_limit)
                                        rd_last <= 1'b1;
                                    else begin
                                        cur_addr <= cur_addr + 5'd1;
                                        rd_byte  <= rd_val(is_ram, cur_addr + 5'd1);
                                    end
                                end
                            end
                        end
                    end

                    ST_IGNORE: begin
                        data_oe_q <= 1'b0;
                    end

                    default: begin
                        state     <= ST_IDLE;
                        data_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
